// File: rtl/mcu_pkg.sv
// Shared MCU definitions for the bus D write-back path.
//   - BUS_D_WIDTH : default data width of every bus D source
//   - MD_*        : bus D source select codes
//   - skid_state_e: occupancy states of the 2-entry output skid buffer
package mcu_pkg;

  localparam int BUS_D_WIDTH = 8;

  localparam logic [1:0] MD_ALU  = 2'd0;
  localparam logic [1:0] MD_DMEM = 2'd1;
  localparam logic [1:0] MD_FPGA = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } skid_state_e;

endpackage

// File: rtl/bus_d_mux_pipe_if.sv
// Bus D source-select / write-back handshake bundle.
//   src_data, md, in_valid, in_ready : select beat offered by the MCU core
//   bus_d, bus_d_src, out_valid, out_ready : registered write-back stream
//   err_illegal, err_clr             : sticky illegal-select flag and its clear
// master = the side driving selects and consuming bus D; slave = the mux pipe.
interface bus_d_mux_pipe_if
  import mcu_pkg::*;
#(
  parameter int WIDTH   = BUS_D_WIDTH,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
);

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         md;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         bus_d;
  logic [SEL_W-1:0]         bus_d_src;
  logic                     out_valid;
  logic                     out_ready;
  logic                     err_illegal;
  logic                     err_clr;

  modport master (
    output src_data, md, in_valid, out_ready, err_clr,
    input  in_ready, bus_d, bus_d_src, out_valid, err_illegal
  );

  modport slave (
    input  src_data, md, in_valid, out_ready, err_clr,
    output in_ready, bus_d, bus_d_src, out_valid, err_illegal
  );

endinterface

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready skid buffer with fully registered outputs.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_data_i/in_valid_i   : upstream beat
//   in_ready_o             : registered, low only while both entries are full
//   out_data_o/out_valid_o : output register contents
//   out_ready_i            : downstream accepts the output register
// in_ready_o depends only on state, so out_ready_i never reaches it
// combinationally; the skid register absorbs the beat that arrives while
// the deassertion of in_ready_o is still one cycle away.
module skid_buf_2
  import mcu_pkg::*;
#(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [PW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  skid_state_e   state_q, state_d;
  logic [PW-1:0] out_q, out_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop;

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          out_d   = in_data_i;
          state_d = FULL1;
        end
      end
      FULL1: begin
        if (push && pop) begin
          out_d = in_data_i;
        end else if (push) begin
          skid_d  = in_data_i;
          state_d = FULL2;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL2: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = FULL1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Valid/ready are flopped from the next state rather than decoded from
    // state_q, so they are glitch-free register outputs.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so all flops sample the same
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/bus_d_mux_pipe.sv
// Registered bus D source selector.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bus_d_mux_pipe_if (select beat in, bus D out,
//                sticky illegal-select flag)
// Selects src_data slice md, remembers the last legally selected value, and
// feeds {md, data} through a 2-entry skid buffer. An illegal md sets the sticky
// error flag; ILLEGAL_MODE 0 drops the beat, ILLEGAL_MODE 1 forwards last_legal
// tagged with the illegal code.
module bus_d_mux_pipe
  import mcu_pkg::*;
#(
  parameter int WIDTH        = BUS_D_WIDTH,
  parameter int NUM_SRC      = 3,
  parameter int SEL_W        = 2,
  parameter int ILLEGAL_MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  bus_d_mux_pipe_if.slave   bus
);

  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("bus_d_mux_pipe: NUM_SRC must be at least 2");
  end
  if ((1 << SEL_W) < NUM_SRC) begin : g_bad_sel_w
    $error("bus_d_mux_pipe: SEL_W too narrow for NUM_SRC");
  end
  if (ILLEGAL_MODE != 0 && ILLEGAL_MODE != 1) begin : g_bad_mode
    $error("bus_d_mux_pipe: ILLEGAL_MODE must be 0 or 1");
  end

  localparam int  PW          = WIDTH + SEL_W;
  localparam bit  FWD_ILLEGAL = (ILLEGAL_MODE == 1);

  logic [WIDTH-1:0] sel_data;
  logic             legal;
  logic             accept;
  logic             enq_valid;
  logic [WIDTH-1:0] enq_data;
  logic             skid_in_ready;
  logic [PW-1:0]    out_payload;
  logic [WIDTH-1:0] last_legal_q, last_legal_d;
  logic             err_q, err_d;

  // Explicit compare-per-source mux: illegal codes fall through to zero
  // instead of indexing past the flattened bus.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.md == SEL_W'(k)) sel_data = bus.src_data[k*WIDTH +: WIDTH];
    end
  end

  assign legal  = (int'(bus.md) < NUM_SRC);
  assign accept = bus.in_valid & skid_in_ready;

  // In drop mode an illegal beat is still accepted upstream (in_ready is the
  // skid buffer's), it simply never reaches the buffer.
  assign enq_valid = bus.in_valid & (legal | FWD_ILLEGAL);
  assign enq_data  = legal ? sel_data : last_legal_q;

  assign last_legal_d = (accept && legal) ? sel_data : last_legal_q;

  // A new illegal accept takes priority over a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (accept && !legal)  err_d = 1'b1;
    else if (bus.err_clr)  err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_legal_q <= '0;
      err_q        <= 1'b0;
    end else begin
      last_legal_q <= last_legal_d;
      err_q        <= err_d;
    end
  end

  skid_buf_2 #(
    .PW (PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({bus.md, enq_data}),
    .in_valid_i  (enq_valid),
    .in_ready_o  (skid_in_ready),
    .out_data_o  (out_payload),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready)
  );

  assign bus.in_ready    = skid_in_ready;
  assign bus.bus_d       = out_payload[WIDTH-1:0];
  assign bus.bus_d_src   = out_payload[WIDTH +: SEL_W];
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_bus_d_mux_pipe.sv
// Self-checking bench for bus_d_mux_pipe. Two instances (ILLEGAL_MODE 0 and 1)
// receive identical directed stimulus; a transaction-level model per instance
// (a 2-deep FIFO of {src, data} plus flag/last_legal) predicts the outputs and
// is compared every cycle, with hand-computed literal checks pinning the model.
module tb_bus_d_mux_pipe;
  import mcu_pkg::*;

  typedef struct packed {
    logic [1:0] s;
    logic [7:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_d_mux_pipe_if #(.WIDTH(8), .NUM_SRC(3), .SEL_W(2)) if0 ();
  bus_d_mux_pipe_if #(.WIDTH(8), .NUM_SRC(3), .SEL_W(2)) if1 ();

  bus_d_mux_pipe #(.WIDTH(8), .NUM_SRC(3), .SEL_W(2), .ILLEGAL_MODE(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  bus_d_mux_pipe #(.WIDTH(8), .NUM_SRC(3), .SEL_W(2), .ILLEGAL_MODE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // currently driven inputs (shared by both instances)
  logic        cur_v, cur_ordy, cur_clr;
  logic [1:0]  cur_md;
  logic [23:0] cur_src;

  // model state, index = ILLEGAL_MODE of the instance
  beat_t      mfifo [2][2];
  int         mcnt  [2];
  logic       merr  [2];
  logic       mrdy  [2];
  logic [7:0] mlast [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]  = 0;
      merr[i]  = 1'b0;
      mrdy[i]  = 1'b1;
      mlast[i] = 8'h00;
    end
  endtask

  task automatic model_step();
    logic  acc, xfer, legal;
    beat_t b;
    if (!rst_n) return;
    legal = (cur_md < 2'd3);
    for (int i = 0; i < 2; i++) begin
      acc  = cur_v && mrdy[i];
      xfer = (mcnt[i] > 0) && cur_ordy;
      if (xfer) begin
        mfifo[i][0] = mfifo[i][1];
        mcnt[i]--;
      end
      if (acc) begin
        if (legal) begin
          b.d = cur_src[int'(cur_md)*8 +: 8];
          b.s = cur_md;
          mfifo[i][mcnt[i]] = b;
          mcnt[i]++;
          mlast[i] = b.d;
        end else if (i == 1) begin
          b.d = mlast[i];
          b.s = cur_md;
          mfifo[i][mcnt[i]] = b;
          mcnt[i]++;
        end
      end
      if (acc && !legal) merr[i] = 1'b1;
      else if (cur_clr)  merr[i] = 1'b0;
      mrdy[i] = (mcnt[i] < 2);
    end
  endtask

  task automatic cmp_inst(input int i, input logic ov, input logic ir, input logic er,
                          input logic [7:0] bd, input logic [1:0] bs);
    check($sformatf("dut%0d out_valid", i), ov, mcnt[i] > 0);
    check($sformatf("dut%0d in_ready", i), ir, mrdy[i]);
    check($sformatf("dut%0d err_illegal", i), er, merr[i]);
    if (mcnt[i] > 0) begin
      check($sformatf("dut%0d bus_d", i), bd, mfifo[i][0].d);
      check($sformatf("dut%0d bus_d_src", i), bs, mfifo[i][0].s);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, if0.out_valid, if0.in_ready, if0.err_illegal, if0.bus_d, if0.bus_d_src);
      cmp_inst(1, if1.out_valid, if1.in_ready, if1.err_illegal, if1.bus_d, if1.bus_d_src);
    end
  end

  task automatic set_inputs(input logic v, input logic [1:0] md, input logic [23:0] src,
                            input logic ordy, input logic clr);
    cur_v = v; cur_md = md; cur_src = src; cur_ordy = ordy; cur_clr = clr;
    if0.in_valid = v; if0.md = md; if0.src_data = src; if0.out_ready = ordy; if0.err_clr = clr;
    if1.in_valid = v; if1.md = md; if1.src_data = src; if1.out_ready = ordy; if1.err_clr = clr;
  endtask

  // one clock of stimulus; returns 1 time unit after the rising edge
  task automatic drive(input logic v, input logic [1:0] md, input logic [23:0] src,
                       input logic ordy, input logic clr);
    @(negedge clk);
    set_inputs(v, md, src, ordy, clr);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, " dut0 out_valid"}, if0.out_valid, 1'b0);
    check({tag, " dut0 bus_d"}, if0.bus_d, 8'h00);
    check({tag, " dut0 bus_d_src"}, if0.bus_d_src, 2'd0);
    check({tag, " dut0 err"}, if0.err_illegal, 1'b0);
    check({tag, " dut0 in_ready"}, if0.in_ready, 1'b1);
    check({tag, " dut1 out_valid"}, if1.out_valid, 1'b0);
    check({tag, " dut1 bus_d"}, if1.bus_d, 8'h00);
    check({tag, " dut1 err"}, if1.err_illegal, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_inputs(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // basic select, out_ready = 1: one beat per clock, 1-cycle latency
    drive(1'b1, MD_ALU, 24'h332211, 1'b1, 1'b0);
    check("sel0 bus_d", if0.bus_d, 8'h11);
    check("sel0 valid", if0.out_valid, 1'b1);
    drive(1'b1, MD_DMEM, 24'h332211, 1'b1, 1'b0);
    check("sel1 bus_d", if0.bus_d, 8'h22);
    check("sel1 src", if0.bus_d_src, 2'd1);
    check("sel1 valid", if0.out_valid, 1'b1);
    drive(1'b1, MD_FPGA, 24'h332211, 1'b1, 1'b0);
    check("sel2 bus_d", if1.bus_d, 8'h33);
    check("sel2 src", if1.bus_d_src, 2'd2);
    check("sel2 err", if0.err_illegal, 1'b0);
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);
    check("drain valid", if0.out_valid, 1'b0);

    // backpressure: two accepts fill the buffer, third beat is held off
    drive(1'b1, MD_ALU, 24'h0000A1, 1'b0, 1'b0);
    check("bp1 in_ready", if0.in_ready, 1'b1);
    drive(1'b1, MD_ALU, 24'h0000A2, 1'b0, 1'b0);
    check("bp2 in_ready", if0.in_ready, 1'b0);
    check("bp2 bus_d", if0.bus_d, 8'hA1);
    drive(1'b1, MD_ALU, 24'h0000A3, 1'b0, 1'b0);
    check("bp3 bus_d held", if0.bus_d, 8'hA1);
    check("bp3 valid held", if0.out_valid, 1'b1);
    drive(1'b1, MD_ALU, 24'h0000A3, 1'b1, 1'b0);
    check("rel1 bus_d", if0.bus_d, 8'hA2);
    check("rel1 in_ready", if0.in_ready, 1'b1);
    drive(1'b1, MD_ALU, 24'h0000A3, 1'b1, 1'b0);
    check("rel2 bus_d", if0.bus_d, 8'hA3);
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);

    // illegal select: mode 0 drops, mode 1 forwards last_legal (0xA3)
    drive(1'b1, 2'd3, 24'h777777, 1'b1, 1'b0);
    check("ill m0 err", if0.err_illegal, 1'b1);
    check("ill m0 valid", if0.out_valid, 1'b0);
    check("ill m1 bus_d", if1.bus_d, 8'hA3);
    check("ill m1 src", if1.bus_d_src, 2'd3);
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b1);
    check("clr m0 err", if0.err_illegal, 1'b0);
    check("clr m1 err", if1.err_illegal, 1'b0);

    // mode 1: legal 0x5C then illegal -> second beat repeats 0x5C tagged 3
    drive(1'b1, MD_DMEM, 24'h005C00, 1'b1, 1'b0);
    check("leg5c bus_d", if1.bus_d, 8'h5C);
    drive(1'b1, 2'd3, 24'h999999, 1'b1, 1'b0);
    check("fwd5c bus_d", if1.bus_d, 8'h5C);
    check("fwd5c src", if1.bus_d_src, 2'd3);
    check("fwd5c err", if1.err_illegal, 1'b1);

    // clear then clear+illegal in the same cycle: set wins
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b1);
    drive(1'b1, 2'd3, 24'h0, 1'b1, 1'b1);
    check("setwins m0 err", if0.err_illegal, 1'b1);
    check("setwins m1 err", if1.err_illegal, 1'b1);
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);

    // reset mid-flight from the full state
    drive(1'b1, MD_ALU, 24'h0000E1, 1'b0, 1'b0);
    drive(1'b1, MD_FPGA, 24'hE20000, 1'b0, 1'b0);
    check("full2 in_ready", if0.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_state("midreset");
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);
    check("post-reset in_ready", if0.in_ready, 1'b1);

    // mixed traffic with toggling backpressure, checked by the model
    for (int i = 0; i < 24; i++) begin
      drive((i % 5) != 4, 2'(i % 4),
            {8'h50 + 8'(i), 8'h40 + 8'(i), 8'h30 + 8'(i)},
            ((i / 3) % 2) == 0, i == 13);
    end
    repeat (3) drive(1'b0, MD_ALU, 24'h0, 1'b1, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
